// File: rtl/matmul_ctrl_status_reg.sv
// matmul_ctrl_status_reg: control/status register for the APB matrix engine.
// It latches the control word and checks the N/K/M dimensions against MAX_DIM.
// It issues a one-cycle start pulse and tracks the run through IDLE/RUN/DONE.
// Optional feature macro: CTRL_IRQ_EN. When it is defined, irq_o is a registered
// OR of the sticky flags. When it is undefined, irq_o is tied to 0.
module matmul_ctrl_status_reg #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BUS_WIDTH  = 64,
    parameter int unsigned DIM_W      = 2,
    parameter int unsigned CTRL_W     = 10 + 3 * DIM_W
) (
    input  logic              clk,
    input  logic              reset_ni,
    input  logic              ctrl_wr_en_i,
    input  logic [CTRL_W-1:0] ctrl_wdata_i,
    input  logic              status_clr_i,
    input  logic              engine_done_i,
    output logic              start_o,
    output logic              mode_o,
    output logic [1:0]        write_target_o,
    output logic [1:0]        read_target_o,
    output logic [1:0]        data_flow_o,
    output logic [DIM_W-1:0]  dim_n_o,
    output logic [DIM_W-1:0]  dim_k_o,
    output logic [DIM_W-1:0]  dim_m_o,
    output logic              reload_a_o,
    output logic              reload_b_o,
    output logic [CTRL_W-1:0] ctrl_reg_o,
    output logic [3:0]        status_o,
    output logic              irq_o
);

    localparam int unsigned MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int unsigned N_LSB   = 8;
    localparam int unsigned K_LSB   = 8 + DIM_W;
    localparam int unsigned M_LSB   = 8 + 2 * DIM_W;
    localparam int unsigned RA_BIT  = 8 + 3 * DIM_W;
    localparam int unsigned RB_BIT  = 9 + 3 * DIM_W;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic               start_q, start_d;
    logic               done_q, done_d;
    logic               wr_err_q, wr_err_d;
    logic               cfg_err_q, cfg_err_d;

    logic               accepting;
    logic               wr_start;
    logic               dims_ok;
    logic               launch;
    logic               run_done;

    function automatic logic dim_legal(input logic [DIM_W-1:0] v);
        return (v != '0) && (32'(v) <= MAX_DIM);
    endfunction

    assign accepting = (state_q != RUN);
    assign wr_start  = ctrl_wr_en_i & ctrl_wdata_i[0];
    assign dims_ok   = dim_legal(ctrl_wdata_i[N_LSB +: DIM_W])
                     & dim_legal(ctrl_wdata_i[K_LSB +: DIM_W])
                     & dim_legal(ctrl_wdata_i[M_LSB +: DIM_W]);
    assign launch    = accepting & wr_start & dims_ok;
    assign run_done  = (state_q == RUN) & engine_done_i;

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next-state: a legal start launches a run, and completion moves RUN to DONE.
    // A clear in DONE returns to IDLE, but a start in the same cycle takes priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch) state_d = RUN;
            RUN:     if (engine_done_i) state_d = DONE;
            DONE: begin
                if (launch)            state_d = RUN;
                else if (status_clr_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Register/flag updates: a clear is applied first so that a same-cycle set wins
    always_comb begin
        ctrl_d    = ctrl_q;
        start_d   = launch;
        done_d    = done_q;
        wr_err_d  = wr_err_q;
        cfg_err_d = cfg_err_q;
        if (status_clr_i) begin
            done_d    = 1'b0;
            wr_err_d  = 1'b0;
            cfg_err_d = 1'b0;
        end
        if (accepting && ctrl_wr_en_i) begin
            if (!ctrl_wdata_i[0] || dims_ok) ctrl_d = ctrl_wdata_i;
            else                             cfg_err_d = 1'b1;
        end
        if (launch) done_d = 1'b0;
        if ((state_q == RUN) && ctrl_wr_en_i) wr_err_d = 1'b1;
        if (run_done) begin
            done_d    = 1'b1;
            ctrl_d[0] = 1'b0;
        end
    end

    // Datapath/status flops with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            ctrl_q    <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            wr_err_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            start_q   <= start_d;
            done_q    <= done_d;
            wr_err_q  <= wr_err_d;
            cfg_err_q <= cfg_err_d;
        end
    end

`ifdef CTRL_IRQ_EN
    logic irq_q, irq_d;

    // Interrupt follows the next flag values so it drops together with a clear
    always_comb irq_d = done_d | wr_err_d | cfg_err_d;

    // Interrupt register
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) irq_q <= 1'b0;
        else           irq_q <= irq_d;
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    assign start_o        = start_q;
    assign ctrl_reg_o     = ctrl_q;
    assign mode_o         = ctrl_q[1];
    assign write_target_o = ctrl_q[3:2];
    assign read_target_o  = ctrl_q[5:4];
    assign data_flow_o    = ctrl_q[7:6];
    assign dim_n_o        = ctrl_q[N_LSB +: DIM_W];
    assign dim_k_o        = ctrl_q[K_LSB +: DIM_W];
    assign dim_m_o        = ctrl_q[M_LSB +: DIM_W];
    assign reload_a_o     = ctrl_q[RA_BIT];
    assign reload_b_o     = ctrl_q[RB_BIT];
    assign status_o       = {cfg_err_q, wr_err_q, done_q, state_q == RUN};

endmodule
